reduction_flag_stream: RTL and testbench

//   Streaming stage downstream of the 16-bit reduction datapath: accepts data words on a

---
 rtl/reduction_flag_stream.sv | 189 ++++++++++++++++++
 tb/tb_reduction_flag_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reduction_flag_stream.sv
// rtl/reduction_flag_stream.sv - per-beat reduction flags and frame summary stream stage
//
// Purpose:
//   Accepts WIDTH-bit words on a valid/ready handshake and presents one registered
//   beat of 8 reduction flags per accepted word (1-cycle latency, full throughput).
//   Across each in_last-delimited frame it accumulates AND/OR/XOR reductions and a
//   saturating beat count, loaded into frm_* on the last beat.
//   Optional feature macro: FRAME_PARITY_CHECK_EN (sticky frame parity checker).
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_data word, in_last frame end
//   in_par                expected frame parity on the last beat (parity build only)
//   out_valid/out_ready   output handshake; out_flags, out_last
//   frm_valid             out_valid & out_last
//   frm_and/or/xor/beats  frame summary held until the next frame end
//   par_err               sticky parity error (tied 0 without FRAME_PARITY_CHECK_EN)
module reduction_flag_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_flags,
  output logic             out_last,
  output logic             frm_valid,
  output logic             frm_and,
  output logic             frm_or,
  output logic             frm_xor,
  output logic [CNT_W-1:0] frm_beats,
  output logic             par_err,
  input  logic             in_par
);

  localparam int H = WIDTH / 2;
  localparam int Q = WIDTH / 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_flags_q, out_flags_d;
  logic             out_last_q, out_last_d;
  logic             acc_and_q, acc_and_d;
  logic             acc_or_q, acc_or_d;
  logic             acc_xor_q, acc_xor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frm_and_q, frm_and_d;
  logic             frm_or_q, frm_or_d;
  logic             frm_xor_q, frm_xor_d;
  logic [CNT_W-1:0] frm_beats_q, frm_beats_d;

  logic             in_fire;
  logic [7:0]       beat_flags;
  // Accumulator values including the current beat.
  logic             acc_and_nx, acc_or_nx, acc_xor_nx;
  logic [CNT_W-1:0] cnt_nx;

  assign in_ready = ~out_valid_q | out_ready;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    beat_flags    = 8'h00;
    beat_flags[0] = &in_data[WIDTH-1:H];
    beat_flags[1] = |in_data[H-1:0];
    beat_flags[2] = ^in_data[WIDTH-Q-1:Q];
    beat_flags[3] = &in_data;
    beat_flags[4] = |in_data;
    beat_flags[5] = ^in_data;
    beat_flags[6] = (&in_data[H-1:0]) | (&in_data[WIDTH-1:H]);
    beat_flags[7] = (^in_data[Q-1:0]) & (|in_data[WIDTH-1:WIDTH-Q]);
  end

  // In IDLE the incoming beat starts a fresh frame, so the accumulators are
  // seeded from it instead of merged; this is how the re-arm after in_last works.
  always_comb begin
    if (state_q == IDLE) begin
      acc_and_nx = beat_flags[3];
      acc_or_nx  = beat_flags[4];
      acc_xor_nx = beat_flags[5];
      cnt_nx     = CNT_W'(1);
    end else begin
      acc_and_nx = acc_and_q & beat_flags[3];
      acc_or_nx  = acc_or_q | beat_flags[4];
      acc_xor_nx = acc_xor_q ^ beat_flags[5];
      cnt_nx     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_flags_d = out_flags_q;
    out_last_d  = out_last_q;
    acc_and_d   = acc_and_q;
    acc_or_d    = acc_or_q;
    acc_xor_d   = acc_xor_q;
    cnt_d       = cnt_q;
    frm_and_d   = frm_and_q;
    frm_or_d    = frm_or_q;
    frm_xor_d   = frm_xor_q;
    frm_beats_d = frm_beats_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_flags_d = beat_flags;
      out_last_d  = in_last;
      acc_and_d   = acc_and_nx;
      acc_or_d    = acc_or_nx;
      acc_xor_d   = acc_xor_nx;
      cnt_d       = cnt_nx;
      if (in_last) begin
        state_d     = IDLE;
        frm_and_d   = acc_and_nx;
        frm_or_d    = acc_or_nx;
        frm_xor_d   = acc_xor_nx;
        frm_beats_d = cnt_nx;
      end else begin
        state_d = IN_FRAME;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_flags_q <= 8'h00;
      out_last_q  <= 1'b0;
      acc_and_q   <= 1'b0;
      acc_or_q    <= 1'b0;
      acc_xor_q   <= 1'b0;
      cnt_q       <= '0;
      frm_and_q   <= 1'b0;
      frm_or_q    <= 1'b0;
      frm_xor_q   <= 1'b0;
      frm_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_flags_q <= out_flags_d;
      out_last_q  <= out_last_d;
      acc_and_q   <= acc_and_d;
      acc_or_q    <= acc_or_d;
      acc_xor_q   <= acc_xor_d;
      cnt_q       <= cnt_d;
      frm_and_q   <= frm_and_d;
      frm_or_q    <= frm_or_d;
      frm_xor_q   <= frm_xor_d;
      frm_beats_q <= frm_beats_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flags = out_flags_q;
  assign out_last  = out_last_q;
  assign frm_valid = out_valid_q & out_last_q;
  assign frm_and   = frm_and_q;
  assign frm_or    = frm_or_q;
  assign frm_xor   = frm_xor_q;
  assign frm_beats = frm_beats_q;

`ifdef FRAME_PARITY_CHECK_EN
  logic par_err_q, par_err_d;

  always_comb begin
    par_err_d = par_err_q;
    if (in_fire && in_last && (acc_xor_nx != in_par)) par_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`else
  logic unused_in_par;
  assign unused_in_par = in_par;
  assign par_err       = 1'b0;
`endif

endmodule

// File: tb/tb_reduction_flag_stream.sv
// tb/tb_reduction_flag_stream.sv - randomized self-checking bench for reduction_flag_stream
module tb_reduction_flag_stream;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          in_par = 1'b0;
  logic          out_ready = 1'b0;

  logic          a_in_ready, a_out_valid, a_out_last, a_frm_valid;
  logic          a_frm_and, a_frm_or, a_frm_xor, a_par_err;
  logic [7:0]    a_out_flags, a_frm_beats;
  logic          b_in_ready, b_out_valid, b_out_last, b_frm_valid;
  logic          b_frm_and, b_frm_or, b_frm_xor, b_par_err;
  logic [7:0]    b_out_flags;
  logic [1:0]    b_frm_beats;

  always #5 clk = ~clk;

  reduction_flag_stream #(.WIDTH(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_flags(a_out_flags), .out_last(a_out_last),
    .frm_valid(a_frm_valid), .frm_and(a_frm_and), .frm_or(a_frm_or),
    .frm_xor(a_frm_xor), .frm_beats(a_frm_beats), .par_err(a_par_err),
    .in_par(in_par));

  reduction_flag_stream #(.WIDTH(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_flags(b_out_flags), .out_last(b_out_last),
    .frm_valid(b_frm_valid), .frm_and(b_frm_and), .frm_or(b_frm_or),
    .frm_xor(b_frm_xor), .frm_beats(b_frm_beats), .par_err(b_par_err),
    .in_par(in_par));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] flags;
    logic       last;
  } beat_t;

  beat_t        out_q[$];   // beat currently held in the output register
  logic [W-1:0] frame_words[$];
  logic         m_and, m_or, m_xor, m_par;
  int           m_beats;

  function automatic int ones(input logic [W-1:0] d, input int hi, input int lo);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (d[i]) n++;
    return n;
  endfunction

  function automatic logic all1(input logic [W-1:0] d, input int hi, input int lo);
    return ones(d, hi, lo) == (hi - lo + 1);
  endfunction

  function automatic logic any1(input logic [W-1:0] d, input int hi, input int lo);
    return ones(d, hi, lo) > 0;
  endfunction

  function automatic logic odd(input logic [W-1:0] d, input int hi, input int lo);
    return (ones(d, hi, lo) % 2) == 1;
  endfunction

  function automatic logic [7:0] ref_flags(input logic [W-1:0] d);
    logic [7:0] f;
    f[0] = all1(d, 15, 8);
    f[1] = any1(d, 7, 0);
    f[2] = odd(d, 11, 4);
    f[3] = all1(d, 15, 0);
    f[4] = any1(d, 15, 0);
    f[5] = odd(d, 15, 0);
    f[6] = all1(d, 7, 0) | all1(d, 15, 8);
    f[7] = odd(d, 3, 0) & any1(d, 15, 12);
    return f;
  endfunction

  task automatic model_reset();
    out_q.delete();
    frame_words.delete();
    m_and = 0; m_or = 0; m_xor = 0; m_par = 0; m_beats = 0;
  endtask

  task automatic model_accept(input logic [W-1:0] d, input logic l, input logic p);
    beat_t b;
    int    total;
    b.flags = ref_flags(d);
    b.last  = l;
    out_q.push_back(b);
    frame_words.push_back(d);
    if (l) begin
      m_and = 1; m_or = 0; total = 0;
      foreach (frame_words[i]) begin
        if (frame_words[i] != '1) m_and = 0;
        if (frame_words[i] != '0) m_or = 1;
        total += ones(frame_words[i], 15, 0);
      end
      m_xor   = (total % 2) == 1;
      m_beats = frame_words.size();
`ifdef FRAME_PARITY_CHECK_EN
      if (m_xor != p) m_par = 1;
`endif
      frame_words.delete();
    end
  endtask

  task automatic check_outputs();
    logic exp_valid;
    exp_valid = out_q.size() > 0;
    check("out_valid", a_out_valid, exp_valid);
    check("b_out_valid", b_out_valid, exp_valid);
    if (exp_valid) begin
      check("out_flags", a_out_flags, out_q[0].flags);
      check("out_last", a_out_last, out_q[0].last);
      check("frm_valid", a_frm_valid, out_q[0].last);
    end else begin
      check("frm_valid_idle", a_frm_valid, 0);
    end
    check("frm_and", a_frm_and, m_and);
    check("frm_or", a_frm_or, m_or);
    check("frm_xor", a_frm_xor, m_xor);
    check("frm_beats", a_frm_beats, (m_beats > 255) ? 255 : m_beats);
    check("frm_beats_sat2", b_frm_beats, (m_beats > 3) ? 3 : m_beats);
    check("par_err", a_par_err, m_par);
  endtask

  // One clock of stimulus: check outputs from the last edge, drive new inputs,
  // then record the transfers that the next edge will perform.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l,
                       input logic p, input logic ordy);
    @(negedge clk);
    check_outputs();
    in_valid = v; in_data = d; in_last = l; in_par = p; out_ready = ordy;
    #1;
    check("in_ready", a_in_ready, (out_q.size() == 0) || ordy);
    check("b_in_ready", b_in_ready, (out_q.size() == 0) || ordy);
    if (a_out_valid && ordy && out_q.size() > 0) void'(out_q.pop_front());
    if (v && a_in_ready) model_accept(d, l, p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; out_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_flags", a_out_flags, 0);
    check("rst_out_last", a_out_last, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    do_reset();
    check_outputs();

    // reset mid-frame: partial frame discarded, next frame counts from 1
    cycle(1, 16'h1234, 0, 0, 1);
    cycle(1, 16'hABCD, 0, 0, 1);
    do_reset();
    check_outputs();
    cycle(1, 16'h0F0F, 1, 0, 1);
    drain();

    // single beat FF00
    cycle(1, 16'hFF00, 1, 0, 1);
    drain();

    // 3-beat frame
    cycle(1, 16'hFFFF, 0, 0, 1);
    cycle(1, 16'hFFFF, 0, 0, 1);
    cycle(1, 16'h0001, 1, 1, 1);
    drain();

    // back-pressure: 5 stalled cycles with in_valid held
    cycle(1, 16'h8001, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 16'hC3C3, 0, 0, 0);
    cycle(1, 16'hC3C3, 1, 0, 1);
    drain();

    // 6-beat frame saturates the 2-bit counter
    for (int i = 0; i < 6; i++) cycle(1, W'($urandom), i == 5, 0, 1);
    drain();

    // all-ones frame keeps frm_and set
    for (int i = 0; i < 4; i++) cycle(1, 16'hFFFF, i == 3, 0, 1);
    drain();

    // long frame: exercises 8-bit counter saturation
    for (int i = 0; i < 260; i++) cycle(1, W'($urandom), i == 259, 0, 1);
    drain();

`ifdef FRAME_PARITY_CHECK_EN
    cycle(1, 16'h0001, 1, 0, 1);
    drain();
    cycle(1, 16'h0003, 1, 0, 1);
    drain();
    do_reset();
    check_outputs();
`endif

    // randomized traffic with random valid/ready and frame lengths
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] d;
      int           sel;
      sel = $urandom_range(0, 9);
      d = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : W'($urandom);
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 4) == 0,
            1'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
